// File: rtl/scr_pkt_loader.sv
// TS packet loader for the CSA scrambler: parses headers, fills a 2x256-byte
// ping-pong buffer and hands one scrambling job per complete packet.
module scr_pkt_loader #(
  parameter int unsigned PKT_LEN   = 188,
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  parameter logic [12:0] NULL_PID  = 13'h1FFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [0:7]       ts_din,
  input  logic             ts_valid,
  input  logic             ts_sop,
  output logic             ts_ready,
  input  logic             scr_en,
  input  logic             cw_par,
  input  logic [0:63]      ck_odd,
  input  logic [0:63]      ck_even,
  input  logic [0:8]       bcradd,
  output logic [0:7]       pb,
  output logic             pkt_eop,
  output logic             buffh,
  output logic [0:7]       pt,
  output logic [0:63]      ck,
  output logic             o_e,
  output logic             enc,
  input  logic             scend,
  output logic [0:CNT_W-1] sync_err_cnt
);
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DEPTH    = 512;
  localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0]  PT_NONE  = 8'(PKT_LEN);
  localparam logic [7:0]  AF_MAX   = 8'(PKT_LEN - 5);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIX} state_t;
  typedef enum logic [1:0] {H_EMPTY, H_FULL, H_BUSY} half_t;

  state_t           state, state_nxt;
  half_t            half_st [2];
  half_t            half_nxt [2];
  logic             wr_half, wr_half_nxt, disp_half, busy, busy_nxt, disp, ready_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [0:4]       pid_hi, pid_hi_nxt;
  logic [0:7]       pid_lo, pid_lo_nxt, hdr3, hdr3_nxt, af_len, af_len_nxt;
  logic             par_q, par_nxt, acc;
  logic             we;
  logic [ADDR_W-1:0] waddr;
  logic [0:7]       wdata;
  logic [1:0]       err_inc;
  logic [CNT_W+1:0] err_sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       pt_h [2];
  logic [1:0]       enc_h, par_h;
  logic [7:0]       pt_c, job_pt;
  logic             enc_c, job_enc, job_par, fix_byp;
  logic [0:7]       hdr3_out;
  logic [0:7]       mem [DEPTH];

  assign acc = ts_valid & ts_ready;

  // Header decode from the held bytes; valid once the packet is fully loaded
  always_comb begin
    pt_c = PT_NONE;
    case (hdr3[2:3])
      2'b01:   pt_c = 8'd4;
      2'b11:   pt_c = (af_len > AF_MAX) ? PT_NONE : (af_len + 8'd5);
      default: pt_c = PT_NONE;
    endcase
    enc_c    = scr_en & (hdr3[0:1] == 2'b00) & ({pid_hi, pid_lo} != NULL_PID) & (pt_c < PT_NONE);
    hdr3_out = enc_c ? {1'b1, par_q, hdr3[2:7]} : hdr3;
  end

  // Load FSM, half bookkeeping and dispatch decision
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pid_hi_nxt  = pid_hi;
    pid_lo_nxt  = pid_lo;
    hdr3_nxt    = hdr3;
    af_len_nxt  = af_len;
    par_nxt     = par_q;
    we          = 1'b0;
    waddr       = '0;
    wdata       = '0;
    err_inc     = 2'd0;
    half_nxt    = half_st;
    wr_half_nxt = wr_half;
    busy_nxt    = busy;
    disp        = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (acc && ts_sop) begin
          if (state == S_LOAD) err_inc = err_inc + 2'd1;
          if (ts_din == SYNC_BYTE) begin
            we        = 1'b1;
            waddr     = {wr_half, 8'd0};
            wdata     = ts_din;
            idx_nxt   = 8'd1;
            state_nxt = S_LOAD;
          end else begin
            err_inc   = err_inc + 2'd1;
            state_nxt = S_IDLE;
          end
        end else if (acc && state == S_LOAD) begin
          case (idx)
            8'd1:    pid_hi_nxt = ts_din[3:7];
            8'd2:    pid_lo_nxt = ts_din;
            8'd3:    begin hdr3_nxt = ts_din; par_nxt = cw_par; end
            8'd4:    af_len_nxt = ts_din;
            default: ;
          endcase
          we      = (idx != 8'd3);
          waddr   = {wr_half, idx};
          wdata   = ts_din;
          idx_nxt = idx + 8'd1;
          if (idx == LAST_IDX) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        we                = 1'b1;
        waddr             = {wr_half, 8'd3};
        wdata             = hdr3_out;
        half_nxt[wr_half] = H_FULL;
        wr_half_nxt       = ~wr_half;
        state_nxt         = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (scend && busy) begin
      busy_nxt        = 1'b0;
      half_nxt[buffh] = H_EMPTY;
    end
    if (half_nxt[disp_half] == H_FULL && !busy_nxt) begin
      disp                = 1'b1;
      busy_nxt            = 1'b1;
      half_nxt[disp_half] = H_BUSY;
    end
    ready_nxt = (half_nxt[wr_half_nxt] == H_EMPTY) && (state_nxt != S_FIX);
  end

  // A half completing in FIX can dispatch on the same edge, before its job info is stored
  assign fix_byp = (state == S_FIX) && (wr_half == disp_half);
  assign job_pt  = fix_byp ? pt_c  : pt_h[disp_half];
  assign job_enc = fix_byp ? enc_c : enc_h[disp_half];
  assign job_par = fix_byp ? par_q : par_h[disp_half];

  assign err_sum = {2'b00, sync_err_cnt} + (CNT_W+2)'(err_inc);
  assign cnt_nxt = (err_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      half_st[0]   <= H_EMPTY;
      half_st[1]   <= H_EMPTY;
      wr_half      <= 1'b0;
      disp_half    <= 1'b0;
      busy         <= 1'b0;
      idx          <= '0;
      pid_hi       <= '0;
      pid_lo       <= '0;
      hdr3         <= '0;
      af_len       <= '0;
      par_q        <= 1'b0;
      pt_h[0]      <= '0;
      pt_h[1]      <= '0;
      enc_h        <= '0;
      par_h        <= '0;
      ts_ready     <= 1'b1;
      pb           <= '0;
      pkt_eop      <= 1'b0;
      buffh        <= 1'b0;
      pt           <= '0;
      ck           <= '0;
      o_e          <= 1'b0;
      enc          <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      state        <= state_nxt;
      half_st      <= half_nxt;
      wr_half      <= wr_half_nxt;
      busy         <= busy_nxt;
      idx          <= idx_nxt;
      pid_hi       <= pid_hi_nxt;
      pid_lo       <= pid_lo_nxt;
      hdr3         <= hdr3_nxt;
      af_len       <= af_len_nxt;
      par_q        <= par_nxt;
      ts_ready     <= ready_nxt;
      pb           <= mem[bcradd];
      pkt_eop      <= disp;
      sync_err_cnt <= cnt_nxt;
      if (state == S_FIX) begin
        pt_h[wr_half]  <= pt_c;
        enc_h[wr_half] <= enc_c;
        par_h[wr_half] <= par_q;
      end
      if (disp) begin
        buffh     <= disp_half;
        pt        <= job_pt;
        enc       <= job_enc;
        o_e       <= job_par;
        ck        <= job_par ? ck_odd : ck_even;
        disp_half <= ~disp_half;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_scr_pkt_loader.sv
// Directed bench for scr_pkt_loader: header decode, ping-pong dispatch,
// backpressure, sync errors and reset behaviour.
module tb_scr_pkt_loader;
  localparam logic [63:0] K_ODD  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K_EVEN = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  ts_din;
  logic        ts_valid, ts_sop, ts_ready;
  logic        scr_en, cw_par;
  logic [63:0] ck_odd, ck_even;
  logic [8:0]  bcradd;
  logic [7:0]  pb;
  logic        pkt_eop, buffh;
  logic [7:0]  pt;
  logic [63:0] ck;
  logic        o_e, enc, scend;
  logic [15:0] sync_err_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int eop_cnt = 0;
  int e0;

  scr_pkt_loader dut (
    .clk(clk), .nrst(nrst), .ts_din(ts_din), .ts_valid(ts_valid), .ts_sop(ts_sop),
    .ts_ready(ts_ready), .scr_en(scr_en), .cw_par(cw_par), .ck_odd(ck_odd),
    .ck_even(ck_even), .bcradd(bcradd), .pb(pb), .pkt_eop(pkt_eop), .buffh(buffh),
    .pt(pt), .ck(ck), .o_e(o_e), .enc(enc), .scend(scend), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pkt_eop) eop_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic sop);
    int n = 0;
    ts_din = b;
    ts_sop = sop;
    ts_valid = 1'b1;
    while (!ts_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ts_ready) chk("ts_ready_wait", {63'd0, ts_ready}, 64'd1);
    @(negedge clk);
    ts_valid = 1'b0;
    ts_sop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] first, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       v = first;
        1:       v = b1;
        2:       v = b2;
        3:       v = b3;
        4:       v = b4;
        default: v = pay(i);
      endcase
      send_byte(v, i == 0);
    end
  endtask

  task automatic chk_job(input string tag, input logic exp_h, input logic [7:0] exp_pt,
                         input logic exp_enc, input logic exp_oe);
    chk({tag, "_eop"},   {63'd0, pkt_eop}, 64'd1);
    chk({tag, "_buffh"}, {63'd0, buffh}, {63'd0, exp_h});
    chk({tag, "_pt"},    {56'd0, pt}, {56'd0, exp_pt});
    chk({tag, "_enc"},   {63'd0, enc}, {63'd0, exp_enc});
    chk({tag, "_oe"},    {63'd0, o_e}, {63'd0, exp_oe});
    chk({tag, "_ck"},    ck, exp_oe ? K_ODD : K_EVEN);
  endtask

  task automatic read_pb(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    bcradd = addr;
    @(negedge clk);
    chk(tag, {56'd0, pb}, {56'd0, exp});
  endtask

  task automatic pulse_scend();
    scend = 1'b1;
    @(negedge clk);
    scend = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; ts_din = '0; ts_valid = 1'b0; ts_sop = 1'b0;
    scr_en = 1'b1; cw_par = 1'b0; ck_odd = K_ODD; ck_even = K_EVEN;
    bcradd = '0; scend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, ts_ready}, 64'd1);
    chk("rst_eop", {63'd0, pkt_eop}, 64'd0);
    chk("rst_cnt", {48'd0, sync_err_cnt}, 64'd0);
    nrst = 1'b1;
    @(negedge clk);

    // PID 0x100, AFC 01, TSC 00, odd key
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("p1", 1'b0, 8'd4, 1'b1, 1'b1);
    ck_odd = ~K_ODD;
    @(negedge clk);
    chk("p1_ck_hold", ck, K_ODD);
    chk("p1_eop_drop", {63'd0, pkt_eop}, 64'd0);
    ck_odd = K_ODD;
    read_pb("p1_hdr3", 9'h003, 8'hD0);
    read_pb("p1_sync", 9'h000, 8'h47);
    read_pb("p1_pay", 9'd100, pay(100));
    pulse_scend();

    // AFC 11, AF length 10, even key
    cw_par = 1'b0;
    send_pkt(8'h47, 8'h02, 8'h00, 8'h30, 8'd10, 188);
    @(negedge clk);
    chk_job("p2", 1'b1, 8'd15, 1'b1, 1'b0);
    read_pb("p2_hdr3", 9'h103, 8'hB0);
    pulse_scend();

    // AF length 184 leaves no payload
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h02, 8'h00, 8'h30, 8'd184, 188);
    @(negedge clk);
    chk_job("p3", 1'b0, 8'd188, 1'b0, 1'b1);
    read_pb("p3_hdr3", 9'h003, 8'h30);
    pulse_scend();

    // Null PID
    cw_par = 1'b0;
    send_pkt(8'h47, 8'h1F, 8'hFF, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("p4", 1'b1, 8'd4, 1'b0, 1'b0);
    read_pb("p4_hdr3", 9'h103, 8'h10);
    pulse_scend();

    // Already scrambled on input (TSC 10)
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h90, 8'h00, 188);
    @(negedge clk);
    chk_job("p5", 1'b0, 8'd4, 1'b0, 1'b1);
    read_pb("p5_hdr3", 9'h003, 8'h90);
    pulse_scend();

    // Scrambling globally disabled
    scr_en = 1'b0;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("p6", 1'b1, 8'd4, 1'b0, 1'b1);
    read_pb("p6_hdr3", 9'h103, 8'h10);
    scr_en = 1'b1;
    pulse_scend();

    // Back-to-back packets with the scrambler stalled
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("bA", 1'b0, 8'd4, 1'b1, 1'b1);
    cw_par = 1'b0;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h30, 8'd0, 188);
    @(negedge clk);
    chk("bB_ready_low", {63'd0, ts_ready}, 64'd0);
    chk("bB_no_eop", {63'd0, pkt_eop}, 64'd0);
    repeat (3) @(negedge clk);
    chk("bB_ready_still_low", {63'd0, ts_ready}, 64'd0);
    pulse_scend();
    chk_job("bB", 1'b1, 8'd5, 1'b1, 1'b0);
    chk("bB_ready_back", {63'd0, ts_ready}, 64'd1);
    pulse_scend();
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h03, 8'h00, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("bC", 1'b0, 8'd4, 1'b1, 1'b1);
    pulse_scend();

    // Bad sync byte: packet dropped
    e0 = eop_cnt;
    send_pkt(8'h48, 8'h01, 8'h00, 8'h10, 8'h00, 188);
    repeat (3) @(negedge clk);
    chk("drop_cnt", {48'd0, sync_err_cnt}, 64'd1);
    chk("drop_no_eop", 64'(eop_cnt), 64'(e0));

    // Early sop at idx 100 aborts; the new packet loads normally
    cw_par = 1'b0;
    send_pkt(8'h47, 8'h05, 8'h00, 8'h10, 8'h00, 100);
    send_pkt(8'h47, 8'h01, 8'h00, 8'h30, 8'd10, 188);
    @(negedge clk);
    chk_job("abort", 1'b1, 8'd15, 1'b1, 1'b0);
    chk("abort_cnt", {48'd0, sync_err_cnt}, 64'd2);
    read_pb("abort_hdr3", 9'h103, 8'hB0);
    read_pb("abort_pay", {1'b1, 8'd50}, pay(50));

    // Reset while a job is busy and the other half is mid-load
    send_pkt(8'h47, 8'h01, 8'h00, 8'h10, 8'h00, 50);
    nrst = 1'b0;
    #1;
    chk("mrst_ready", {63'd0, ts_ready}, 64'd1);
    chk("mrst_eop", {63'd0, pkt_eop}, 64'd0);
    chk("mrst_buffh", {63'd0, buffh}, 64'd0);
    chk("mrst_pt", {56'd0, pt}, 64'd0);
    chk("mrst_enc", {63'd0, enc}, 64'd0);
    chk("mrst_ck", ck, 64'd0);
    chk("mrst_cnt", {48'd0, sync_err_cnt}, 64'd0);
    chk("mrst_pb", {56'd0, pb}, 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    cw_par = 1'b1;
    send_pkt(8'h47, 8'h01, 8'h00, 8'h10, 8'h00, 188);
    @(negedge clk);
    chk_job("post_rst", 1'b0, 8'd4, 1'b1, 1'b1);
    chk("post_rst_cnt", {48'd0, sync_err_cnt}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scr_pkt_loader.md
Name: scr_pkt_loader

Overview:
Upstream feeder for the CSA scrambler core. Accepts a byte-serial 188-byte TS stream and parses the header. Writes each packet into a 2 x 256-byte ping-pong buffer that the scrambler reads through bcradd/pb. When a packet is complete, it hands the scrambler one packet job (pkt_eop, buffh, pt, ck, o_e, enc) and frees the buffer half on scend.

Parameters:
PKT_LEN, 188, bytes per TS packet
SYNC_BYTE, 8'h47, required first byte
NULL_PID, 13'h1FFF, PID never scrambled
CNT_W, 16, width of error counter

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
ts_din  in  [0:7]  TS byte, bit 0 = MSB
ts_valid  in  1  ts_din valid this cycle
ts_sop  in  1  first byte of packet, qualified by ts_valid
ts_ready  out  1  loader can accept a byte
scr_en  in  1  global scrambling enable
cw_par  in  1  key parity for next packet: 1 = odd, 0 = even
ck_odd  in  [0:63]  odd control word
ck_even  in  [0:63]  even control word
bcradd  in  [0:8]  scrambler read address {half, byte index}
pb  out  [0:7]  buffer read data
pkt_eop  out  1  one-cycle job-start pulse to scrambler
buffh  out  1  buffer half holding the job
pt  out  [0:7]  payload start offset within the packet (4..188)
ck  out  [0:63]  selected control word, held for the job
o_e  out  1  parity of ck
enc  out  1  1 = scramble payload, 0 = pass through
scend  in  1  scrambler job-done pulse
sync_err_cnt  out  [0:CNT_W-1]  saturating error count

Behaviour:
- Reset: all outputs 0 except ts_ready = 1. Both halves EMPTY, write half = 0, scrambler-busy flag = 0. Reset mid-load or mid-job discards everything; buffer RAM contents are don't-care.
- Buffer: 512x8 dual-port RAM. Write port is internal. Read port: pb = mem[bcradd] registered, 1-cycle latency, always enabled.
- Half state per half: EMPTY -> FULL (packet complete) -> BUSY (dispatched) -> EMPTY (scend).
- ts_ready = 1 iff the current write half is EMPTY and the loader FSM is not in FIX.
- A byte is accepted iff ts_valid & ts_ready.
- Load FSM:
  - IDLE: discard bytes until an accepted byte with ts_sop. If that byte == SYNC_BYTE, write it at index 0 and go to LOAD. Otherwise increment the error count and stay in IDLE.
  - LOAD: write each accepted byte at index idx (idx++). Byte 3 is not written; it is held in a register.
  - LOAD, byte 4: latch as AF length.
  - LOAD, ts_sop before idx = PKT_LEN: abort, increment the error count, and handle that byte as in IDLE on the same half.
  - LOAD: after byte PKT_LEN-1, go to FIX.
  - FIX (1 cycle): write the rewritten byte 3 at index 3, set the half FULL, toggle the write half, go to IDLE.
- Header decode: PID = {byte1[3:7], byte2}. TSC = byte3[0:1], AFC = byte3[2:3].
  - AFC 01: pt = 4.
  - AFC 11: pt = 5 + AF length. If AF length > 183, pt = 188.
  - AFC 00/10: pt = 188.
- enc = scr_en & (TSC == 00) & (PID != NULL_PID) & (pt < 188).
- If enc, byte 3 is written with TSC = {1, cw_par}; otherwise byte 3 is written unchanged.
- cw_par is sampled when byte 3 is accepted and stored per half with pt and enc.
- Dispatch: when the oldest FULL half exists and busy = 0, assert pkt_eop for 1 cycle. In the same cycle, drive buffh, pt, enc, and o_e = stored parity, with ck = ck_odd if o_e else ck_even. Set busy = 1 and the half to BUSY. All job outputs hold until the next dispatch.
- ck is captured at dispatch. Later ck_odd/ck_even changes do not affect the running job.
- scend: clears busy and sets the BUSY half EMPTY in that cycle. The next dispatch is no earlier than the following cycle. scend with busy = 0 is ignored.
- If FIX and scend occur in the same cycle, both updates apply.
- Halves dispatch in fill order (0,1,0,...).
- sync_err_cnt saturates at all-ones.

Test Plan:
- PID 0x0100, AFC 01, TSC 00, scr_en = 1, cw_par = 1, busy = 0 -> pkt_eop on the cycle after FIX, with buffh = 0, pt = 4, enc = 1, o_e = 1, ck = ck_odd. Reading bcradd = 0x003 gives pb[0:1] = 11 one cycle later.
- AFC 11 with AF length 10 -> pt = 15, enc = 1. AF length 184 -> pt = 188, enc = 0, byte 3 unchanged.
- PID 0x1FFF, or TSC = 10 on input, or scr_en = 0 -> enc = 0, header unchanged, job still dispatched.
- Three back-to-back packets with scend withheld -> ts_ready = 0 after the 2nd FIX. Pulse scend -> packet 2 dispatched with buffh = 1 on the next cycle, and ts_ready returns to 1.
- First byte 0x48 -> packet dropped, sync_err_cnt = 1, no pkt_eop. ts_sop at idx 100 -> sync_err_cnt = 2, and the new packet loads and dispatches normally.
- Assert nrst low during LOAD and during a BUSY job -> all outputs 0, ts_ready = 1, and the next packet dispatches with buffh = 0.
